// File: rtl/cpm_skew_feeder.sv
// cpm_skew_feeder
//   Transmit-side feeder for the SYA/CPM array. Accepts whole row vectors
//   over a valid/ready handshake and launches each lane onto a diagonal
//   skew: lane i reaches its output i+1 cycles after the vector is accepted,
//   accompanied by a per-lane capture enable. A tile of CfgLen vectors is
//   fed, the skew is drained, and Done pulses for one cycle.
//
//   Optional build macro: CPM_FEED_STALL_EN adds the OutStall input, which
//   freezes the whole feeder (FSM, counters, skew pipes) while high.
//
// Ports
//   Clk      in   clock, rising edge
//   Rstn     in   asynchronous active-low reset
//   CfgVld   in   tile-start request
//   CfgRdy   out  high only in IDLE; start on CfgVld & CfgRdy
//   CfgLen   in   vectors in the tile, sampled at start
//   InVld    in   input vector valid
//   InRdy    out  feeder can accept a vector
//   InData   in   row vector, lane i = InData[i*DW +: DW]
//   OutStall in   (CPM_FEED_STALL_EN only) freeze request from downstream
//   OutEn    out  per-lane capture enable
//   OutData  out  per-lane data, lane i = OutData[i*DW +: DW]
//   Busy     out  FSM not in IDLE
//   Done     out  one-cycle pulse at tile completion
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a tile start, CfgRdy high
// FEED  | accepting vectors until len_r have been taken
// FLUSH | draining the skew so the last vector reaches lane NUM-1
// DONE  | tile finished; Done pulses on the way back to IDLE

module cpm_skew_feeder #(
  parameter int DW    = 8,
  parameter int NUM   = 4,
  parameter int LEN_W = 8
) (
  input  logic              Clk,
  input  logic              Rstn,
  input  logic              CfgVld,
  output logic              CfgRdy,
  input  logic [LEN_W-1:0]  CfgLen,
  input  logic              InVld,
  output logic              InRdy,
  input  logic [NUM*DW-1:0] InData,
`ifdef CPM_FEED_STALL_EN
  input  logic              OutStall,
`endif
  output logic [NUM-1:0]    OutEn,
  output logic [NUM*DW-1:0] OutData,
  output logic              Busy,
  output logic              Done
);

  localparam int FL_W = $clog2(NUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] acc_cnt;
  logic [FL_W-1:0]  flush_cnt;
  logic             cfg_rdy_q;
  logic             in_rdy_q;
  logic             busy_q;
  logic             done_q;
  logic             adv;
  logic             start;
  logic             accept;
  logic [NUM-1:0]   en_last;

  // adv low freezes every piece of state except the Done pulse register,
  // which must not be stretched by a stall.
`ifdef CPM_FEED_STALL_EN
  assign adv = ~OutStall;
`else
  assign adv = 1'b1;
`endif

  assign CfgRdy  = cfg_rdy_q & adv;
  assign InRdy   = in_rdy_q & adv;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign OutEn   = en_last & {NUM{adv}};
  assign start   = CfgVld & CfgRdy;
  assign accept  = InVld & InRdy;

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state     <= S_IDLE;
      len_r     <= '0;
      acc_cnt   <= '0;
      flush_cnt <= '0;
      cfg_rdy_q <= 1'b1;
      in_rdy_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (adv) begin
        case (state)
          S_IDLE: begin
            if (start) begin
              len_r     <= CfgLen;
              acc_cnt   <= '0;
              cfg_rdy_q <= 1'b0;
              busy_q    <= 1'b1;
              if (CfgLen != '0) begin
                state    <= S_FEED;
                in_rdy_q <= 1'b1;
              end else begin
                state <= S_DONE;
              end
            end
          end
          S_FEED: begin
            if (accept) begin
              acc_cnt <= acc_cnt + LEN_W'(1);
              // Compare against len_r-1 so a full-scale length never needs
              // acc_cnt to reach 2^LEN_W.
              if (acc_cnt == len_r - LEN_W'(1)) begin
                state     <= S_FLUSH;
                in_rdy_q  <= 1'b0;
                flush_cnt <= FL_W'(NUM - 2);
              end
            end
          end
          S_FLUSH: begin
            if (flush_cnt == '0) begin
              state <= S_DONE;
            end else begin
              flush_cnt <= flush_cnt - FL_W'(1);
            end
          end
          S_DONE: begin
            state     <= S_IDLE;
            done_q    <= 1'b1;
            cfg_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            cfg_rdy_q <= 1'b1;
            in_rdy_q  <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Skew pipes: lane i has i+1 stages of {valid, data}. Each data stage only
  // loads when a valid element enters it, so the last stage (OutData) holds
  // its value across bubbles.
  for (genvar i = 0; i < NUM; i++) begin : g_lane
    logic [i:0]    vld_q;
    logic [i:0]    vin;
    logic [DW-1:0] dat_q [0:i];
    logic [DW-1:0] din   [0:i];

    assign vin[0] = accept;
    assign din[0] = InData[i*DW +: DW];
    for (genvar k = 1; k <= i; k++) begin : g_link
      assign vin[k] = vld_q[k-1];
      assign din[k] = dat_q[k-1];
    end

    always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
        vld_q <= '0;
        for (int k = 0; k <= i; k++) dat_q[k] <= '0;
      end else if (adv) begin
        vld_q <= vin;
        for (int k = 0; k <= i; k++) begin
          if (vin[k]) dat_q[k] <= din[k];
        end
      end
    end

    assign en_last[i]          = vld_q[i];
    assign OutData[i*DW +: DW] = dat_q[i];
  end

endmodule

// File: tb/tb_cpm_skew_feeder.sv
module tb_cpm_skew_feeder;

  localparam int DW    = 8;
  localparam int NUM   = 4;
  localparam int LEN_W = 8;
  localparam int BUDGET = 2000;

  logic              Clk = 1'b0;
  logic              Rstn;
  logic              CfgVld;
  logic              CfgRdy;
  logic [LEN_W-1:0]  CfgLen;
  logic              InVld;
  logic              InRdy;
  logic [NUM*DW-1:0] InData;
`ifdef CPM_FEED_STALL_EN
  logic              OutStall;
`endif
  logic [NUM-1:0]    OutEn;
  logic [NUM*DW-1:0] OutData;
  logic              Busy;
  logic              Done;

  int checks   = 0;
  int failures = 0;

  // Reference state: last element seen on each lane, and per-lane queues of
  // pending deliveries keyed by "advancing-cycle index".
  logic [DW-1:0] last_dat [NUM];
  int            q_idx [NUM][$];
  logic [DW-1:0] q_dat [NUM][$];

  cpm_skew_feeder #(.DW(DW), .NUM(NUM), .LEN_W(LEN_W)) dut (
    .Clk     (Clk),
    .Rstn    (Rstn),
    .CfgVld  (CfgVld),
    .CfgRdy  (CfgRdy),
    .CfgLen  (CfgLen),
    .InVld   (InVld),
    .InRdy   (InRdy),
    .InData  (InData),
`ifdef CPM_FEED_STALL_EN
    .OutStall(OutStall),
`endif
    .OutEn   (OutEn),
    .OutData (OutData),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  // Runs one tile through the DUT and checks every output every cycle.
  // Model: each accepted vector at advancing index a delivers lane i at
  // advancing index a+1+i. Stalled cycles do not advance the index and show
  // no enables. The FSM reaches DONE NUM advancing cycles after the last
  // accept (one after start for a zero-length tile); Done pulses the next
  // real cycle.
  task automatic run_tile(input string name, input int len, input int vld_pct,
                          input bit use_pat, input logic [15:0] pat,
                          input bit use_fix, input logic [NUM*DW-1:0] fix_data,
                          input int stall_from, input int stall_to,
                          input int stall_pct, input bit cfg_noise);
    int acc = 0;
    int a_cur = 0;
    int dstate = -1;
    int done_cyc = -1;
    int k = 0;
    bit stall, adv, exp_busy, exp_cfg_rdy, exp_in_rdy, exp_done, finished;
    logic [NUM-1:0]    exp_en;
    logic [NUM*DW-1:0] exp_dat;
    int pending;
    finished = 0;
    for (int i = 0; i < NUM; i++) begin
      q_idx[i].delete();
      q_dat[i].delete();
    end
    while (!finished && k < BUDGET) begin
      @(negedge Clk);
      stall = 0;
      if (k > 0 && k >= stall_from && k < stall_to) stall = 1;
      if (k > 0 && stall_pct > 0 && $urandom_range(99) < stall_pct) stall = 1;
`ifdef CPM_FEED_STALL_EN
      OutStall = stall;
`else
      stall = 0;
`endif
      adv = !stall;
      exp_busy = (k > 0) && (done_cyc < 0 || k < done_cyc);
      if (k == 0) begin
        CfgVld = 1'b1;
        CfgLen = LEN_W'(len);
      end else begin
        CfgVld = cfg_noise && exp_busy;
        CfgLen = LEN_W'($urandom);
      end
      if (use_pat) InVld = (k >= 1 && k <= 16) ? pat[k-1] : 1'b0;
      else         InVld = ($urandom_range(99) < vld_pct);
      InData = use_fix ? fix_data : {$urandom, $urandom};
      #1;
      exp_cfg_rdy = adv && !exp_busy;
      exp_in_rdy  = adv && (k > 0) && (acc < len);
      exp_done    = (k == done_cyc);
      exp_en      = '0;
      for (int i = 0; i < NUM; i++) begin
        if (q_idx[i].size() > 0 && q_idx[i][0] == a_cur) begin
          last_dat[i] = q_dat[i][0];
          exp_en[i]   = adv;
          if (adv) begin
            void'(q_idx[i].pop_front());
            void'(q_dat[i].pop_front());
          end
        end
        exp_dat[i*DW +: DW] = last_dat[i];
      end

      checks++;
      if (CfgRdy !== exp_cfg_rdy) begin
        failures++;
        $display("FAIL %s cyc=%0d CfgRdy got=%b exp=%b", name, k, CfgRdy, exp_cfg_rdy);
      end
      checks++;
      if (InRdy !== exp_in_rdy) begin
        failures++;
        $display("FAIL %s cyc=%0d InRdy got=%b exp=%b", name, k, InRdy, exp_in_rdy);
      end
      checks++;
      if (Busy !== exp_busy) begin
        failures++;
        $display("FAIL %s cyc=%0d Busy got=%b exp=%b", name, k, Busy, exp_busy);
      end
      checks++;
      if (Done !== exp_done) begin
        failures++;
        $display("FAIL %s cyc=%0d Done got=%b exp=%b", name, k, Done, exp_done);
      end
      checks++;
      if (OutEn !== exp_en) begin
        failures++;
        $display("FAIL %s cyc=%0d OutEn got=%b exp=%b", name, k, OutEn, exp_en);
      end
      checks++;
      if (OutData !== exp_dat) begin
        failures++;
        $display("FAIL %s cyc=%0d OutData got=%h exp=%h", name, k, OutData, exp_dat);
      end

      if (adv) begin
        if (exp_in_rdy && InVld) begin
          for (int i = 0; i < NUM; i++) begin
            q_idx[i].push_back(a_cur + 1 + i);
            q_dat[i].push_back(InData[i*DW +: DW]);
          end
          acc++;
          if (acc == len) dstate = a_cur + NUM;
        end
        if (k == 0 && len == 0) dstate = a_cur + 1;
        if (a_cur == dstate) done_cyc = k + 1;
        a_cur++;
      end
      if (done_cyc >= 0 && k >= done_cyc + 2) finished = 1;
      k++;
    end
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s timeout got=%0d cycles exp=done within %0d", name, k, BUDGET);
    end
    pending = 0;
    for (int i = 0; i < NUM; i++) pending += q_idx[i].size();
    checks++;
    if (pending != 0 || acc != len) begin
      failures++;
      $display("FAIL %s drain got=pending %0d accepted %0d exp=pending 0 accepted %0d",
               name, pending, acc, len);
    end
    CfgVld = 1'b0;
    InVld  = 1'b0;
  endtask

  task automatic test_reset;
    Rstn   = 1'b0;
    CfgVld = 1'b0;
    CfgLen = '0;
    InVld  = 1'b0;
    InData = '0;
`ifdef CPM_FEED_STALL_EN
    OutStall = 1'b0;
`endif
    for (int i = 0; i < NUM; i++) last_dat[i] = '0;
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if ({CfgRdy, InRdy, OutEn, OutData, Busy, Done} !== {1'b1, 1'b0, {NUM{1'b0}}, {NUM*DW{1'b0}}, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset got=CfgRdy %b InRdy %b OutEn %b OutData %h Busy %b Done %b exp=1 0 0 0 0 0",
               CfgRdy, InRdy, OutEn, OutData, Busy, Done);
    end
    @(negedge Clk);
    Rstn = 1'b1;
  endtask

  task automatic test_single;
    run_tile("single", 1, 100, 0, 16'h0, 1, 32'h44332211, 0, 0, 0, 0);
    checks++;
    if (OutData !== 32'h44332211) begin
      failures++;
      $display("FAIL single_final OutData got=%h exp=44332211", OutData);
    end
  endtask

  task automatic test_burst;
    run_tile("burst3", 3, 100, 0, 16'h0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_bubble;
    run_tile("bubble101", 2, 0, 1, 16'b101, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_zero_len;
    run_tile("zero_len", 0, 100, 0, 16'h0, 0, '0, 0, 0, 0, 1);
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++)
      run_tile("random", int'($urandom_range(1, 12)), 60, 0, 16'h0, 0, '0, 0, 0, 0, 1);
  endtask

  task automatic test_max_len;
    run_tile("max_len", 255, 100, 0, 16'h0, 0, '0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back;
    run_tile("b2b_a", 2, 100, 0, 16'h0, 0, '0, 0, 0, 0, 0);
    run_tile("b2b_b", 5, 100, 0, 16'h0, 0, '0, 0, 0, 0, 0);
  endtask

`ifdef CPM_FEED_STALL_EN
  task automatic test_stall;
    run_tile("stall3", 6, 100, 0, 16'h0, 0, '0, 3, 6, 0, 0);
    for (int t = 0; t < 4; t++)
      run_tile("stall_rand", int'($urandom_range(0, 10)), 70, 0, 16'h0, 0, '0, 0, 0, 30, 1);
  endtask
`endif

  task automatic test_reset_mid;
    @(negedge Clk);
    CfgVld = 1'b1;
    CfgLen = 8'd4;
    InVld  = 1'b0;
    @(negedge Clk);
    CfgVld = 1'b0;
    InVld  = 1'b1;
    InData = {$urandom, $urandom};
    @(negedge Clk);
    InData = {$urandom, $urandom};
    @(negedge Clk);
    #1;
    checks++;
    if (OutEn[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_inflight OutEn[0] got=%b exp=1", OutEn[0]);
    end
    Rstn = 1'b0;
    #1;
    checks++;
    if ({CfgRdy, InRdy, OutEn, OutData, Busy, Done} !== {1'b1, 1'b0, {NUM{1'b0}}, {NUM*DW{1'b0}}, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got=CfgRdy %b InRdy %b OutEn %b OutData %h Busy %b Done %b exp=1 0 0 0 0 0",
               CfgRdy, InRdy, OutEn, OutData, Busy, Done);
    end
    for (int i = 0; i < NUM; i++) last_dat[i] = '0;
    @(negedge Clk);
    Rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      InVld  = $urandom_range(1);
      InData = {$urandom, $urandom};
      #1;
      checks++;
      if ({OutEn, Done, Busy, InRdy} !== {{NUM{1'b0}}, 3'b000}) begin
        failures++;
        $display("FAIL reset_mid_after cyc=%0d got=OutEn %b Done %b Busy %b InRdy %b exp=0 0 0 0",
                 c, OutEn, Done, Busy, InRdy);
      end
    end
    InVld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_bubble();
    test_zero_len();
    test_random();
    test_max_len();
    test_back_to_back();
`ifdef CPM_FEED_STALL_EN
    test_stall();
`endif
    test_reset_mid();
    test_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpm_skew_feeder.md
Name: cpm_skew_feeder

Overview:
- Transmit-side companion to the per-PE enabled capture registers in the SYA/CPM array.
- Accepts whole row vectors over a valid/ready handshake.
- Emits each lane's element on a diagonal skew: lane i is delayed i cycles, and each element comes with a per-lane enable strobe.
- Sequences one tile of CfgLen vectors, drains the skew, then pulses Done.

Parameters:
- DW, 8, element width in bits.
- NUM, 4, lane count (array edge); NUM >= 2.
- LEN_W, 8, width of the tile-length field.

Ports:
- Clk  in  1  clock, rising edge.
- Rstn  in  1  asynchronous active-low reset.
- CfgVld  in  1  tile-start request.
- CfgRdy  out  1  high only in IDLE; start occurs on CfgVld & CfgRdy.
- CfgLen  in  LEN_W  vectors in the tile, sampled at start.
- InVld  in  1  input vector valid.
- InRdy  out  1  feeder can accept a vector.
- InData  in  NUM*DW  lane i = InData[i*DW +: DW].
- OutEn  out  NUM  per-lane capture enable to the downstream register chain.
- OutData  out  NUM*DW  per-lane data, lane i = OutData[i*DW +: DW].
- Busy  out  1  state != IDLE.
- Done  out  1  one-cycle pulse at tile completion.

Behaviour:
- Clock and reset: single clock. Rstn low asynchronously clears all state to IDLE.
- Reset values: CfgRdy=1; InRdy=0; OutEn=0; OutData=0; Busy=0; Done=0; counters and skew pipes 0.
- FSM states: IDLE, FEED, FLUSH, DONE.
- IDLE:
  - CfgRdy=1.
  - On CfgVld, latch CfgLen into len_r and clear acc_cnt.
  - Go to FEED if CfgLen != 0, else go to DONE.
- FEED:
  - InRdy=1.
  - Accept occurs when InVld & InRdy; acc_cnt increments on each accept.
  - Accept of vector number len_r (acc_cnt == len_r-1) moves to FLUSH next cycle.
  - No vector is accepted in the cycle FEED exits.
- FLUSH:
  - InRdy=0.
  - A flush counter runs NUM-1 cycles so the last vector clears the deepest lane, then goes to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Skew pipe, lane i:
  - Shift register of depth i+1 carrying {valid, data}.
  - Stage 0 loads {accept, InData lane i} every cycle.
  - OutEn[i] = valid at the last stage.
  - OutData lane i is loaded only when that valid is 1, otherwise it holds its last value.
- Latency: vector accepted in cycle t gives OutEn[i]=1 in cycle t+1+i with its element on OutData lane i.
- Bubbles: InVld low in FEED inserts a bubble; OutEn low on lane i i+1 cycles later. Skew alignment between vectors is preserved.
- Throughput: one vector per cycle while InVld stays high.
- Done timing: Done asserts the cycle after lane NUM-1 shows its final OutEn.
- Length arithmetic:
  - acc_cnt is LEN_W bits.
  - CfgLen = 2^LEN_W - 1 is supported without wrap.
  - CfgLen = 0: no OutEn; Done is 1 cycle after the DONE entry (start, then DONE).
- CfgVld outside IDLE is ignored; CfgRdy=0 there.
- Reset mid-tile: in-flight vectors are discarded; no OutEn or Done after Rstn deasserts until a new start.

Optional Feature:
- Macro: CPM_FEED_STALL_EN.
- Defined:
  - Adds input OutStall (1 bit).
  - While OutStall=1: all skew pipes, acc_cnt, the flush counter and the FSM freeze; InRdy=0; OutEn forced 0; OutData holds.
  - Deassertion resumes with skew alignment intact.
  - If OutStall is high in DONE, Done is delayed until OutStall is low, and still lasts one cycle.
- Undefined: no OutStall port; the pipe always advances.

Test Plan (NUM=4, DW=8, LEN_W=8):
- Reset → CfgRdy=1, InRdy=0, OutEn=4'b0000, OutData=0, Done=0.
- CfgLen=1; vector {0x44,0x33,0x22,0x11} (lane3..0) accepted at cycle t → OutEn[0]=1 with lane0=0x11 at t+1, then lane1=0x22 at t+2, lane2=0x33 at t+3, lane3=0x44 at t+4; Done at t+5.
- CfgLen=3, InVld continuous with vectors A, B, C → OutEn[0] high for t+1..t+3 and OutEn[3] high for t+4..t+6; each lane shows A, B, C in order; Done at t+7.
- CfgLen=2, InVld pattern 1,0,1 → OutEn[0] pattern 1,0,1 from t+1; OutEn[2] pattern 1,0,1 from t+3; OutData holds during the bubble.
- CfgLen=0 → no OutEn ever; Done one cycle after IDLE exit; CfgVld while Busy is ignored.
- CfgLen=4, Rstn pulsed low after 2 accepts → all outputs at reset values immediately; no further OutEn or Done. With CPM_FEED_STALL_EN: OutStall high for 3 cycles mid-FEED → OutEn=0 for those cycles, and the lane sequence is otherwise unchanged, shifted by 3.
